// File: rtl/embedded_mode_sel.sv
// embedded_mode_sel: debounced one-hot switch decode driving subsystem enables,
// with a break-before-make handover whenever the granted mode changes.
// state   | meaning
// S_RUN   | mode_id granted, en drives its subsystem
// S_DRAIN | en cleared, waiting for the old subsystem to go idle or time out
// S_GRANT | one cycle, mode_id loaded from the latest request
module embedded_mode_sel #(
  parameter int N_MODES         = 3,
  parameter int DEBOUNCE_CYC    = 1000000,
  parameter int IDLE_TIMEOUT    = 255,
  parameter bit HOLD_ON_INVALID = 1'b1,
  localparam int MW             = $clog2(N_MODES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_MODES-1:0] sw_i,
  input  logic [N_MODES-1:0] busy_i,
  output logic [N_MODES-1:0] en_o,
  output logic [MW-1:0]      mode_id_o,
  output logic               switching_o,
  output logic               invalid_o,
  output logic               timeout_o
);

  localparam int DCW = $clog2(DEBOUNCE_CYC + 1);
  localparam int TCW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [DCW-1:0] DEB_LOAD = DCW'(DEBOUNCE_CYC - 1);
  localparam logic [TCW-1:0] TMO_LIM  = TCW'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_GRANT} state_t;

  logic [N_MODES-1:0] sync1_q, sync2_q, prev_q, stable_vec_q;
  logic [DCW-1:0]     deb_cnt_q;
  state_t             state_q;
  logic [MW-1:0]      mode_id_q, old_q;
  logic [TCW-1:0]     wait_q;
  logic [N_MODES-1:0] en_q;
  logic               switching_q, invalid_q, timeout_q;

  logic [MW-1:0]      ones, idx, req;
  logic               multi, old_busy;

  function automatic logic [N_MODES-1:0] onehot(input logic [MW-1:0] m);
    onehot = '0;
    for (int k = 0; k < N_MODES; k++)
      if (m == MW'(k + 1)) onehot[k] = 1'b1;
  endfunction

  // One down-counter for the whole vector; any change reloads it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      prev_q       <= '0;
      deb_cnt_q    <= '0;
      stable_vec_q <= '0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (sync2_q != prev_q) begin
        if (DEBOUNCE_CYC == 1) stable_vec_q <= sync2_q;
        else                   deb_cnt_q    <= DEB_LOAD;
      end else if (deb_cnt_q != '0) begin
        deb_cnt_q <= deb_cnt_q - DCW'(1);
        if (deb_cnt_q == DCW'(1)) stable_vec_q <= sync2_q;
      end
    end
  end

  always_comb begin
    ones = '0;
    idx  = '0;
    for (int k = 0; k < N_MODES; k++) begin
      if (stable_vec_q[k]) begin
        ones = ones + MW'(1);
        idx  = MW'(k + 1);
      end
    end
    multi = (ones > MW'(1));
    if (ones == '0)  req = '0;
    else if (multi)  req = HOLD_ON_INVALID ? mode_id_q : '0;
    else             req = idx;
  end

  // old_q == 0 matches no bit, so a handover from "no mode" never waits.
  always_comb begin
    old_busy = 1'b0;
    for (int k = 0; k < N_MODES; k++)
      if (old_q == MW'(k + 1)) old_busy = busy_i[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RUN;
      mode_id_q   <= '0;
      old_q       <= '0;
      wait_q      <= '0;
      en_q        <= '0;
      switching_q <= 1'b0;
      invalid_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      invalid_q <= multi;
      timeout_q <= 1'b0;
      case (state_q)
        S_RUN: begin
          if (req != mode_id_q) begin
            old_q       <= mode_id_q;
            wait_q      <= '0;
            en_q        <= '0;
            switching_q <= 1'b1;
            state_q     <= S_DRAIN;
          end else begin
            en_q        <= onehot(mode_id_q);
            switching_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (!old_busy) begin
            state_q <= S_GRANT;
          end else if (wait_q == TMO_LIM) begin
            timeout_q <= 1'b1;
            state_q   <= S_GRANT;
          end else begin
            wait_q <= wait_q + TCW'(1);
          end
        end
        S_GRANT: begin
          mode_id_q   <= req;
          en_q        <= onehot(req);
          switching_q <= 1'b0;
          state_q     <= S_RUN;
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign en_o        = en_q;
  assign mode_id_o   = mode_id_q;
  assign switching_o = switching_q;
  assign invalid_o   = invalid_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_embedded_mode_sel.sv
// Bench for embedded_mode_sel: two instances (hold / force-zero on invalid)
// against a cycle model built from the switch-to-grant rules.
module tb_embedded_mode_sel;

  localparam int NM   = 3;
  localparam int DEB  = 4;
  localparam int TMO  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] sw   = 3'b000;
  logic [2:0] busy = 3'b000;

  logic [2:0] en_h, en_z;
  logic [1:0] mode_h, mode_z;
  logic swg_h, swg_z, inv_h, inv_z, tmo_h, tmo_z;

  int checks = 0;
  int errors = 0;

  int sw_hi_cnt = 0, zero_cnt = 0, tmo_cnt = 0, chg_cnt = 0;
  logic [2:0] or_acc = 3'b000;
  logic [15:0] prev_vec = '0;

  always #5 clk = ~clk;

  embedded_mode_sel #(.N_MODES(NM), .DEBOUNCE_CYC(DEB), .IDLE_TIMEOUT(TMO),
                      .HOLD_ON_INVALID(1'b1)) u_dut_h (
    .clk(clk), .rst(rst), .sw_i(sw), .busy_i(busy), .en_o(en_h),
    .mode_id_o(mode_h), .switching_o(swg_h), .invalid_o(inv_h), .timeout_o(tmo_h));

  embedded_mode_sel #(.N_MODES(NM), .DEBOUNCE_CYC(DEB), .IDLE_TIMEOUT(TMO),
                      .HOLD_ON_INVALID(1'b0)) u_dut_z (
    .clk(clk), .rst(rst), .sw_i(sw), .busy_i(busy), .en_o(en_z),
    .mode_id_o(mode_z), .switching_o(swg_z), .invalid_o(inv_z), .timeout_o(tmo_z));

  // Model state: index 0 holds on invalid, index 1 forces mode 0.
  int m_mode [2], m_phase [2], m_old [2], m_entry [2];
  logic [2:0] m_en [2];
  bit m_swg [2], m_inv [2], m_tmo [2];
  logic [2:0] m_s1, m_s2, m_last, m_stable;
  int m_run, m_cyc;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] oh(input int m);
    return (m == 0) ? 3'b000 : 3'(32'd1 << (m - 1));
  endfunction

  function automatic int req_of(input logic [2:0] v, input int mode, input bit hold);
    int n;
    n = $countones(v);
    if (n == 0) return 0;
    if (n > 1)  return hold ? mode : 0;
    for (int k = 0; k < 3; k++) if (v[k]) return k + 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_phase[i] = 0; m_old[i] = 0; m_entry[i] = 0;
      m_en[i] = 3'b000; m_swg[i] = 0; m_inv[i] = 0; m_tmo[i] = 0;
    end
    m_s1 = 3'b000; m_s2 = 3'b000; m_last = 3'b000; m_stable = 3'b000;
    m_run = 0; m_cyc = 0;
  endtask

  // phase 0 = running, 1 = draining, 2 = granting
  task automatic model_step();
    int req;
    bit drained;
    m_cyc++;
    for (int i = 0; i < 2; i++) begin
      req = req_of(m_stable, m_mode[i], i == 0);
      m_inv[i] = ($countones(m_stable) > 1);
      m_tmo[i] = 0;
      case (m_phase[i])
        0: begin
          if (req != m_mode[i]) begin
            m_old[i] = m_mode[i]; m_phase[i] = 1; m_entry[i] = m_cyc;
            m_en[i] = 3'b000; m_swg[i] = 1;
          end else begin
            m_en[i] = oh(m_mode[i]); m_swg[i] = 0;
          end
        end
        1: begin
          drained = (m_old[i] == 0) || !busy[m_old[i] - 1];
          if (drained) m_phase[i] = 2;
          else if (m_cyc - m_entry[i] == TMO + 1) begin
            m_tmo[i] = 1; m_phase[i] = 2;
          end
        end
        default: begin
          m_mode[i] = req; m_en[i] = oh(req); m_swg[i] = 0; m_phase[i] = 0;
        end
      endcase
    end
    if (m_s2 == m_last) m_run++;
    else                m_run = 1;
    m_last = m_s2;
    if (m_run == DEB) m_stable = m_s2;
    m_s2 = m_s1;
    m_s1 = sw;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  task automatic cmp_inst(input int i, input logic [2:0] en, input logic [1:0] md,
                          input logic sg, input logic iv, input logic to);
    chk($sformatf("inst%0d en", i), int'(en), int'(m_en[i]));
    chk($sformatf("inst%0d mode_id", i), int'(md), m_mode[i]);
    chk($sformatf("inst%0d switching", i), int'(sg), int'(m_swg[i]));
    chk($sformatf("inst%0d invalid", i), int'(iv), int'(m_inv[i]));
    chk($sformatf("inst%0d timeout", i), int'(to), int'(m_tmo[i]));
    chk($sformatf("inst%0d en onehot", i), int'($countones(en) <= 1), 1);
    chk($sformatf("inst%0d en during handover", i), int'(sg && (en != 3'b000)), 0);
  endtask

  initial begin
    logic [15:0] cur;
    forever begin
      @(negedge clk);
      cmp_inst(0, en_h, mode_h, swg_h, inv_h, tmo_h);
      cmp_inst(1, en_z, mode_z, swg_z, inv_z, tmo_z);
      sw_hi_cnt += int'(swg_h);
      zero_cnt  += int'(en_h == 3'b000);
      tmo_cnt   += int'(tmo_h);
      or_acc    |= en_h;
      cur = {en_h, mode_h, swg_h, inv_h, tmo_h, en_z, mode_z, swg_z, inv_z, tmo_z};
      if (cur != prev_vec) chg_cnt++;
      prev_vec = cur;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " en_h"}, int'(en_h), 0);       chk({tag, " en_z"}, int'(en_z), 0);
    chk({tag, " mode_h"}, int'(mode_h), 0);   chk({tag, " mode_z"}, int'(mode_z), 0);
    chk({tag, " sw_h"}, int'(swg_h), 0);      chk({tag, " sw_z"}, int'(swg_z), 0);
    chk({tag, " inv_h"}, int'(inv_h), 0);     chk({tag, " inv_z"}, int'(inv_z), 0);
    chk({tag, " tmo_h"}, int'(tmo_h), 0);     chk({tag, " tmo_z"}, int'(tmo_z), 0);
  endtask

  initial begin
    #1 rst = 1'b1;
    tick(3);
    check_zero("reset");
    rst = 1'b0;
    tick(2);

    // First grant: 2 sync + 4 debounce + 3 handover cycles
    sw = 3'b001; sw_hi_cnt = 0;
    tick(8);
    chk("first pre-grant en", int'(en_h), 0);
    chk("first grant switching", int'(swg_h), 1);
    tick(1);
    chk("first en", int'(en_h), 1);
    chk("first mode", int'(mode_h), 1);
    chk("first switching low", int'(swg_h), 0);
    chk("first switching cycles", sw_hi_cnt, 2);

    // Reset in the middle of a drain
    sw = 3'b010;
    tick(7);
    chk("mid drain switching", int'(swg_h), 1);
    #2 rst = 1'b1;
    #1 check_zero("mid-drain reset");
    sw = 3'b001;
    tick(2);
    rst = 1'b0;
    tick(12);
    chk("after reset en", int'(en_h), 1);
    chk("after reset mode", int'(mode_h), 1);

    // Old subsystem busy for 3 cycles after en drops
    sw = 3'b010;
    tick(6);
    zero_cnt = 0; tmo_cnt = 0;
    tick(1);
    busy = 3'b001;
    tick(3);
    busy = 3'b000;
    tick(2);
    chk("short busy en", int'(en_h), 2);
    chk("short busy mode", int'(mode_h), 2);
    tick(1);
    chk("short busy en-zero cycles", zero_cnt, 5);
    chk("short busy no timeout", tmo_cnt, 0);

    // Old subsystem stuck busy: timeout path
    sw = 3'b100; busy = 3'b010;
    tick(6);
    zero_cnt = 0; tmo_cnt = 0;
    tick(10);
    chk("timeout pulse", int'(tmo_h), 1);
    chk("timeout grant en", int'(en_h), 0);
    tick(1);
    chk("timeout en", int'(en_h), 4);
    chk("timeout mode", int'(mode_h), 3);
    chk("timeout pulse gone", int'(tmo_h), 0);
    tick(1);
    chk("timeout en-zero cycles", zero_cnt, 10);
    chk("timeout pulse count", tmo_cnt, 1);
    busy = 3'b000;

    // Short glitch to a two-bit vector is filtered
    sw = 3'b001;
    tick(12);
    chk("pre glitch en", int'(en_h), 1);
    chg_cnt = 0;
    sw = 3'b011;
    tick(3);
    sw = 3'b001;
    tick(12);
    chk("glitch output changes", chg_cnt, 0);
    chk("glitch en", int'(en_h), 1);

    // Held two-bit vector: hold vs force zero
    sw = 3'b011;
    tick(6);
    chk("invalid latency", int'(inv_h), 0);
    tick(1);
    chk("invalid hold", int'(inv_h), 1);
    tick(2);
    chk("hold en", int'(en_h), 1);
    chk("hold mode", int'(mode_h), 1);
    chk("zero invalid", int'(inv_z), 1);
    chk("zero en", int'(en_z), 0);
    chk("zero mode", int'(mode_z), 0);

    // Request returns to the old mode mid-drain
    sw = 3'b001;
    tick(12);
    chk("regrant start z", int'(mode_z), 1);
    sw = 3'b010; busy = 3'b001; or_acc = 3'b000; tmo_cnt = 0;
    tick(8);
    sw = 3'b001;
    tick(14);
    chk("regrant en", int'(en_h), 1);
    chk("regrant mode", int'(mode_h), 1);
    chk("regrant en z", int'(en_z), 1);
    chk("regrant no foreign bit", int'(or_acc), 1);
    chk("regrant timeout count", tmo_cnt, 1);
    busy = 3'b000;

    // All switches off from mode 2
    sw = 3'b010;
    tick(12);
    chk("mode2 en", int'(en_h), 2);
    sw = 3'b000;
    tick(8);
    chk("off grant switching", int'(swg_h), 1);
    tick(1);
    chk("off en", int'(en_h), 0);
    chk("off mode", int'(mode_h), 0);
    chk("off switching", int'(swg_h), 0);

    // From mode 0 the busy wait is skipped
    busy = 3'b111; sw = 3'b001;
    tick(8);
    chk("from zero pre en", int'(en_h), 0);
    tick(1);
    chk("from zero en", int'(en_h), 1);
    chk("from zero mode", int'(mode_h), 1);
    busy = 3'b000;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/embedded_mode_sel.md
# embedded_mode_sel

Parametrised mode-select control unit that sits between the board slide switches and the embedded subsystems (stopwatch/watch, SR04, DHT11, and any later additions). It synchronises and debounces N switch inputs, validates that they are one-hot, and drives a one-hot enable vector plus an encoded mode number. Mode changes go through a break-before-make handover: the old subsystem's enable drops, and the block waits for that subsystem to report idle or for a timeout to expire before it enables the new one.

## Interface
- N_MODES, 3, number of selectable subsystems (1..15).
- DEBOUNCE_CYC, 1000000, consecutive stable clk cycles required to accept a new switch vector (≥1).
- IDLE_TIMEOUT, 255, maximum DRAIN cycles spent waiting for the old subsystem's busy to fall (≥1).
- HOLD_ON_INVALID, 1, behaviour on a multi-bit switch vector: 1 keeps the current mode, 0 forces mode 0.
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- sw  input  N_MODES  raw, asynchronous switch inputs; bit k requests mode k+1.
- busy  input  N_MODES  per-subsystem busy, synchronous to clk; bit k belongs to mode k+1.
- en  output  N_MODES  one-hot subsystem enable; all zero when mode is 0 or during handover.
- mode_id  output  MW  current granted mode; 0 means none. MW = ceil(log2(N_MODES+1)).
- switching  output  1  high while in DRAIN or GRANT.
- invalid  output  1  high while the debounced vector has more than one bit set.
- timeout  output  1  one-cycle pulse when a DRAIN ends by timeout.

## Operation
- Synchroniser: 2-flop synchroniser on every sw bit.
- Debounce: a single counter covers the whole synchronised vector. Any change in the vector restarts the count. The vector is copied into stable_vec once it has been unchanged for DEBOUNCE_CYC consecutive cycles.
- Decode of stable_vec into req:
  - zero bits set: req = 0;
  - exactly one bit k set: req = k+1;
  - more than one bit set: invalid = 1, and req = mode_id if HOLD_ON_INVALID = 1, else req = 0.
- FSM states: RUN, DRAIN, GRANT.
  - RUN: en = onehot(mode_id). If req ≠ mode_id, latch old = mode_id, clear en, clear the wait counter, and go to DRAIN.
  - DRAIN: en = 0, switching = 1.
    - If old = 0, or busy[old-1] = 0, go to GRANT next cycle.
    - Otherwise increment the wait counter. When the counter reaches IDLE_TIMEOUT with busy still high, pulse timeout and go to GRANT.
  - GRANT: one cycle, en = 0. mode_id is loaded with req as sampled in this cycle. If that value equals old, the old mode is re-granted. Then go to RUN.
- req changing during DRAIN or GRANT does not restart the handover; the latest req is taken at GRANT. A req change in the same cycle as the return to RUN is handled by RUN on the next cycle.
- The block never asserts more than one en bit, and never asserts any en bit during DRAIN or GRANT.

## Timing
- Reset values: en = 0, mode_id = 0, switching = 0, invalid = 0, timeout = 0, stable_vec = 0, synchroniser and counters = 0, state = RUN.
- rst asserted in any state, including mid-DRAIN, returns the block to the reset values immediately. No handover completes.
- All outputs are registered.
- sw change to stable_vec update: 2 synchroniser cycles + DEBOUNCE_CYC cycles.
- stable_vec update at cycle T:
  - en = 0 and switching = 1 at T+1;
  - with the drain condition met at T+1: GRANT at T+2, then new en and mode_id valid at T+3, switching = 0 at T+3.
- Timeout path: en = 0 for IDLE_TIMEOUT+2 cycles. timeout is high for exactly the first GRANT cycle.
- invalid follows stable_vec with 1 cycle of latency.
- A switch bounce shorter than DEBOUNCE_CYC produces no change on any output.

## Test plan
Bench parameters: N_MODES=3, DEBOUNCE_CYC=4, IDLE_TIMEOUT=8, busy=0 unless stated.
- Reset then sw=3'b001 held → en=3'b001, mode_id=1 at 2+4+3 cycles after the sw edge; switching high for exactly 2 cycles. Asserting rst mid-sequence → all outputs 0 immediately.
- sw=001→010 with busy[0] held high for 3 cycles after en drops → en=000 for 5 cycles, then en=010, mode_id=2, timeout never pulses.
- sw=010→100 with busy[1] stuck high → en=000 for 10 cycles, one-cycle timeout pulse, then en=100, mode_id=3.
- sw=001, then glitch to 011 for 3 cycles → no output change. Then sw=011 held: with HOLD_ON_INVALID=1 → invalid=1, en stays 001; with HOLD_ON_INVALID=0 → invalid=1, en=000, mode_id=0 after handover.
- During DRAIN, sw returns to the original mode → handover completes and the old mode is re-granted; en never shows two bits or a foreign bit.
- sw=000 from mode 2 → en=000, mode_id=0 after handover. sw=001 from mode 0 → DRAIN skips the busy wait (old=0), en=001 three cycles after the stable_vec update.
